bbox_scanner: RTL and testbench
===============================

# bbox_scanner

Consumes one triangle bounding box (XMIN/XMAX/YMIN/YMAX, 10.6 unsigned fixed point, already rounded to whole pixels) per handshake. Walks every pixel inside it in raster order, one per cycle, and emits each pixel-centre sample coordinate to the downstream edge-function/coverage stage. It is the reader side of the bounding-box interface and sits between the bounding-box stage and per-pixel inside testing.

## Interface
- COORD_W, 16, coordinate width in bits
- FRAC_BITS, 6, fractional bits; integer part is bits [COORD_W-1:FRAC_BITS]
- SCREEN_W, 320, screen width in pixels (clip bound)
- SCREEN_H, 240, screen height in pixels (clip bound)
- CNT_W, 17, pixel counter width
- CLK  in  1  single clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- XMIN, XMAX, YMIN, YMAX  in  COORD_W each  box bounds, inclusive; fractional bits ignored
- bbox_valid  in  1  box inputs valid
- bbox_ready  out  1  scanner idle, will accept box
- px, py  out  COORD_W each  pixel-centre sample: {int, 1'b1, (FRAC_BITS-1)'b0}
- pix_valid  out  1  px/py valid
- pix_ready  in  1  downstream accepts pixel
- pix_last  out  1  current pixel is last of this box
- done  out  1  one-cycle pulse, box fully scanned (or empty)
- pix_count  out  CNT_W  pixels emitted for the most recent box; stable from done until next accept

## Operation
- Reset values: bbox_ready=0 for the reset cycle itself and 1 from the first IDLE cycle; pix_valid=0; pix_last=0; done=0; px=py=0; pix_count=0; state=IDLE.
- IDLE: bbox_ready=1. On bbox_valid&&bbox_ready, latch integer parts xmin/xmax/ymin/ymax (truncate fraction), clear pix_count, set cx=xmin, cy=ymin.
  - Box empty (xmin>xmax or ymin>ymax, evaluated after clipping) -> DONE.
  - Otherwise -> SCAN.
- SCAN: bbox_ready=0, pix_valid=1, px/py from cx/cy. pix_last=(cx==xmax && cy==ymax). On pix_valid&&pix_ready, pix_count++, then:
  - cx<xmax: cx++.
  - cx==xmax, cy<ymax: cx=xmin, cy++.
  - Both at max: state goes to DONE.
  - Without pix_ready, px/py/pix_last hold.
- DONE: done=1 for exactly one cycle, pix_valid=0, then IDLE.
- Arithmetic: cx/cy are COORD_W-FRAC_BITS bits unsigned. Comparisons are unsigned. No wrap, because cx never exceeds xmax.
- bbox_valid while not IDLE: ignored; the box is not consumed.
- RST mid-scan: immediate return to reset values. The partial box is dropped and no done is issued.

## Timing
- Accept cycle N -> first pixel valid at cycle N+1 (registered outputs).
- Throughput is 1 pixel/cycle with pix_ready held high. A box of W×H pixels occupies cycles N+1..N+W·H, with done at N+W·H+1 and bbox_ready high at N+W·H+2.
- Empty box: done at N+1, ready at N+2, no pix_valid.
- Row wrap costs no bubble.
- Minimum spacing between accepted boxes is W·H+2 cycles.

## Configuration
- BBOX_SCANNER_CLIP_EN defined:
  - On accept, clamp xmax to SCREEN_W-1 and ymax to SCREEN_H-1.
  - If xmin≥SCREEN_W or ymin≥SCREEN_H, treat the box as empty.
  - Emitted pixels are always on-screen.
- Undefined: bounds are used as given, with no clamping. Only min>max is treated as empty.

## Structure
- Package bbox_pkg:
  - COORD_W, FRAC_BITS, INT_W=COORD_W-FRAC_BITS.
  - HALF_PIX constant (1<<(FRAC_BITS-1)).
  - State enum {IDLE, SCAN, DONE}.
  - Shared by the bounding-box stage and this block.
- One sub-module, bbox_clip: combinational clamp and empty detection on the latched integer bounds. Under BBOX_SCANNER_CLIP_EN it is instantiated; otherwise it reduces to the min>max check.

## Test plan
- Box X 2..4, Y 1..2 (XMIN=0x0080, XMAX=0x0100, YMIN=0x0040, YMAX=0x0080), pix_ready=1 -> 6 pixels. First px=0x00A0/py=0x0060, row-wrap pixel px=0x00A0/py=0x00A0, last px=0x0120/py=0x00A0 with pix_last=1. done the next cycle, pix_count=6.
- Same box, pix_ready toggling 1,0,1,0 -> px/py stable while stalled, no pixel skipped or duplicated, still 6 pixels.
- XMIN=0x0140 (5) > XMAX=0x00C0 (3) -> no pix_valid, done at accept+1, pix_count=0.
- Single pixel X=Y=7 -> one pixel px=py=0x01E0 with pix_last=1, done next cycle. Fraction bits set on inputs (XMIN=0x01FF) are ignored.
- With BBOX_SCANNER_CLIP_EN and SCREEN_W=320: XMIN=318, XMAX=400, Y 0..0 -> 2 pixels (x=318,319). XMIN=330 -> empty.
- RST asserted after the 3rd pixel of a 4×4 box -> outputs zero asynchronously, no done. The next box is scanned correctly from its first pixel.

Source files
------------

// File: rtl/bbox_scanner_pkg.sv
// bbox_pkg: coordinate format, screen bounds and scanner state shared by the
// bounding-box stage and bbox_scanner.
package bbox_pkg;
   localparam int COORD_W   = 16;
   localparam int FRAC_BITS = 6;
   localparam int INT_W     = COORD_W - FRAC_BITS;
   localparam int SCREEN_W  = 320;
   localparam int SCREEN_H  = 240;
   localparam int CNT_W     = 17;
   localparam logic [COORD_W-1:0] HALF_PIX = COORD_W'(1 << (FRAC_BITS - 1));
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
endpackage

// File: rtl/bbox_scanner_if.sv
// bbox_if / pix_if: bounding-box input bus and pixel-sample output bus.
interface bbox_if;
   import bbox_pkg::*;
   logic [COORD_W-1:0] xmin, xmax, ymin, ymax;
   logic               bbox_valid, bbox_ready;
   modport master(output xmin, xmax, ymin, ymax, bbox_valid, input bbox_ready);
   modport slave(input xmin, xmax, ymin, ymax, bbox_valid, output bbox_ready);
endinterface

interface pix_if;
   import bbox_pkg::*;
   logic [COORD_W-1:0] px, py;
   logic               pix_valid, pix_ready, pix_last;
   modport master(output px, py, pix_valid, pix_last, input pix_ready);
   modport slave(input px, py, pix_valid, pix_last, output pix_ready);
endinterface

// File: rtl/bbox_scanner_clip.sv
// bbox_clip: screen clamp and empty-box detection on integer pixel bounds;
// clamping only exists when BBOX_SCANNER_CLIP_EN is defined.
module bbox_clip
   import bbox_pkg::*;
(
   input  logic [INT_W-1:0] xmin,
   input  logic [INT_W-1:0] xmax,
   input  logic [INT_W-1:0] ymin,
   input  logic [INT_W-1:0] ymax,
   output logic [INT_W-1:0] xmax_clip,
   output logic [INT_W-1:0] ymax_clip,
   output logic             empty
);
`ifdef BBOX_SCANNER_CLIP_EN
   localparam logic [INT_W-1:0] XLIM = INT_W'(SCREEN_W - 1);
   localparam logic [INT_W-1:0] YLIM = INT_W'(SCREEN_H - 1);
   assign xmax_clip = xmax > XLIM ? XLIM : xmax;
   assign ymax_clip = ymax > YLIM ? YLIM : ymax;
   // an off-screen min always exceeds the clamped max, so this also covers it
   assign empty = xmin > xmax_clip || ymin > ymax_clip;
`else
   assign xmax_clip = xmax;
   assign ymax_clip = ymax;
   assign empty = xmin > xmax || ymin > ymax;
`endif
endmodule

// File: rtl/bbox_scanner.sv
// bbox_scanner: walks each accepted bounding box in raster order, one pixel-centre
// sample per cycle. Define BBOX_SCANNER_CLIP_EN to clip boxes to the screen.
module bbox_scanner
   import bbox_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   bbox_if.slave            bb,
   pix_if.master            pix,
   output logic             done,
   output logic [CNT_W-1:0] pix_count
);
   state_t           state, nxt;
   logic             rdy;
   logic [INT_W-1:0] cx, cy, xmin, xmax, ymax;
   logic [INT_W-1:0] in_xmin, in_xmax, in_ymin, in_ymax, xmax_clip, ymax_clip;
   logic             empty, accept, fire, at_end;
   logic             unused_frac;

   assign in_xmin = bb.xmin[COORD_W-1:FRAC_BITS];
   assign in_xmax = bb.xmax[COORD_W-1:FRAC_BITS];
   assign in_ymin = bb.ymin[COORD_W-1:FRAC_BITS];
   assign in_ymax = bb.ymax[COORD_W-1:FRAC_BITS];
   assign unused_frac = ^{bb.xmin[FRAC_BITS-1:0], bb.xmax[FRAC_BITS-1:0],
                          bb.ymin[FRAC_BITS-1:0], bb.ymax[FRAC_BITS-1:0]};

   bbox_clip u_clip (
      .xmin(in_xmin), .xmax(in_xmax), .ymin(in_ymin), .ymax(in_ymax),
      .xmax_clip(xmax_clip), .ymax_clip(ymax_clip), .empty(empty)
   );

   always_comb begin
      accept = state == IDLE && rdy && bb.bbox_valid;
      fire   = state == SCAN && pix.pix_ready;
      at_end = cx == xmax && cy == ymax;
      nxt    = state == IDLE ? (accept ? (empty ? DONE : SCAN) : IDLE)
             : state == SCAN ? (fire && at_end ? DONE : SCAN) : IDLE;
   end

   // ready is registered so it stays low through the reset cycle itself
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rdy       <= 1'b0;
         cx        <= '0;
         cy        <= '0;
         xmin      <= '0;
         xmax      <= '0;
         ymax      <= '0;
         pix_count <= '0;
      end else begin
         state <= nxt;
         rdy   <= nxt == IDLE;
         if (accept) begin
            xmin      <= in_xmin;
            xmax      <= xmax_clip;
            ymax      <= ymax_clip;
            cx        <= in_xmin;
            cy        <= in_ymin;
            pix_count <= '0;
         end else if (fire) begin
            pix_count <= pix_count + 1'b1;
            if (!at_end) begin
               cx <= cx == xmax ? xmin : cx + 1'b1;
               cy <= cx == xmax ? cy + 1'b1 : cy;
            end
         end
      end
   end

   assign bb.bbox_ready = rdy;
   assign pix.pix_valid = state == SCAN;
   assign pix.pix_last  = state == SCAN && at_end;
   assign pix.px        = state == SCAN ? {cx, {FRAC_BITS{1'b0}}} | HALF_PIX : '0;
   assign pix.py        = state == SCAN ? {cy, {FRAC_BITS{1'b0}}} | HALF_PIX : '0;
   assign done          = state == DONE;
endmodule

// File: tb/tb_bbox_scanner.sv
// tb_bbox_scanner: directed and randomized checks of bbox_scanner against a
// raster-order pixel list model.
module tb_bbox_scanner;
   import bbox_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic done;
   logic [CNT_W-1:0] pix_count;
   bbox_if bb();
   pix_if  pix();
   bbox_scanner dut (.clk(clk), .rst(rst), .bb(bb.slave), .pix(pix.master),
                     .done(done), .pix_count(pix_count));
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int hold_viol;
   logic [15:0] obs_x[$], obs_y[$], exp_x[$], exp_y[$];
   logic        obs_last[$], exp_last[$];

   // expected samples: every integer pixel of the (optionally clipped) box, raster order
   function automatic void build_exp(input logic [15:0] x0, x1, y0, y1);
      int a = int'(x0) / 64, b = int'(x1) / 64, c = int'(y0) / 64, d = int'(y1) / 64;
`ifdef BBOX_SCANNER_CLIP_EN
      if (b > SCREEN_W - 1) b = SCREEN_W - 1;
      if (d > SCREEN_H - 1) d = SCREEN_H - 1;
      if (a >= SCREEN_W || c >= SCREEN_H) b = a - 1;
`endif
      exp_x.delete(); exp_y.delete(); exp_last.delete();
      for (int y = c; y <= d; y++)
         for (int x = a; x <= b; x++) begin
            exp_x.push_back(16'(x * 64 + 32));
            exp_y.push_back(16'(y * 64 + 32));
            exp_last.push_back(x == b && y == d);
         end
   endfunction

   // mode 0: ready always, 1: ready alternates 1,0, 2: random ready
   task automatic scan_box(input logic [15:0] x0, x1, y0, y1, input int mode,
                           output int done_cyc, output int cnt);
      int cyc;
      bit rdy, stalled;
      logic [15:0] hx, hy;
      logic hl;
      obs_x.delete(); obs_y.delete(); obs_last.delete();
      hold_viol = 0; done_cyc = -1; cnt = -1; stalled = 0;
      hx = '0; hy = '0; hl = 1'b0;
      cyc = 0;
      while (bb.bbox_ready !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
      bb.xmin = x0; bb.xmax = x1; bb.ymin = y0; bb.ymax = y1;
      bb.bbox_valid = 1'b1; pix.pix_ready = 1'b0;
      @(negedge clk);
      bb.bbox_valid = 1'b0;
      for (cyc = 1; cyc < 4000; cyc++) begin
         if (stalled && (pix.pix_valid !== 1'b1 || pix.px !== hx || pix.py !== hy || pix.pix_last !== hl))
            hold_viol++;
         if (done === 1'b1) begin done_cyc = cyc; cnt = int'(pix_count); break; end
         rdy = mode == 0 ? 1'b1 : mode == 1 ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
         pix.pix_ready = rdy;
         stalled = pix.pix_valid === 1'b1 && !rdy;
         hx = pix.px; hy = pix.py; hl = pix.pix_last;
         if (pix.pix_valid === 1'b1 && rdy) begin
            obs_x.push_back(pix.px); obs_y.push_back(pix.py); obs_last.push_back(pix.pix_last);
         end
         @(negedge clk);
      end
      pix.pix_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (bb.bbox_ready !== 1'b0 || pix.pix_valid !== 1'b0 || pix.pix_last !== 1'b0 || done !== 1'b0 ||
          pix.px !== 16'h0 || pix.py !== 16'h0 || pix_count !== '0) begin
         errors++;
         $display("FAIL reset_vals got rdy=%b v=%b l=%b d=%b px=%h py=%h cnt=%0d want all zero",
                  bb.bbox_ready, pix.pix_valid, pix.pix_last, done, pix.px, pix.py, pix_count);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bb.bbox_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready got %b want 1", bb.bbox_ready);
      end
   endtask

   task automatic test_basic();
      int dc, cnt;
      build_exp(16'h0080, 16'h0100, 16'h0040, 16'h0080);
      scan_box(16'h0080, 16'h0100, 16'h0040, 16'h0080, 0, dc, cnt);
      checks++;
      if (obs_x.size() != 6 || exp_x.size() != 6) begin
         errors++; $display("FAIL basic_npix got %0d want 6", obs_x.size());
      end else begin
         checks++;
         if (obs_x[0] !== 16'h00A0 || obs_y[0] !== 16'h0060) begin
            errors++; $display("FAIL basic_first got %h/%h want 00a0/0060", obs_x[0], obs_y[0]);
         end
         checks++;
         if (obs_x[3] !== 16'h00A0 || obs_y[3] !== 16'h00A0) begin
            errors++; $display("FAIL basic_wrap got %h/%h want 00a0/00a0", obs_x[3], obs_y[3]);
         end
         checks++;
         if (obs_x[5] !== 16'h0120 || obs_y[5] !== 16'h00A0 || obs_last[5] !== 1'b1) begin
            errors++; $display("FAIL basic_last got %h/%h/%b want 0120/00a0/1", obs_x[5], obs_y[5], obs_last[5]);
         end
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs_x[i] !== exp_x[i] || obs_y[i] !== exp_y[i] || obs_last[i] !== exp_last[i]) begin
               errors++;
               $display("FAIL basic_pix%0d got %h/%h/%b want %h/%h/%b", i, obs_x[i], obs_y[i], obs_last[i],
                        exp_x[i], exp_y[i], exp_last[i]);
            end
         end
      end
      checks++;
      if (dc != 7 || cnt != 6) begin
         errors++; $display("FAIL basic_done got cyc=%0d cnt=%0d want cyc=7 cnt=6", dc, cnt);
      end
      @(negedge clk);
      checks++;
      if (bb.bbox_ready !== 1'b1 || done !== 1'b0 || pix_count !== 17'd6) begin
         errors++;
         $display("FAIL basic_after got rdy=%b done=%b cnt=%0d want 1/0/6", bb.bbox_ready, done, pix_count);
      end
   endtask

   task automatic test_stall();
      int dc, cnt;
      build_exp(16'h0080, 16'h0100, 16'h0040, 16'h0080);
      scan_box(16'h0080, 16'h0100, 16'h0040, 16'h0080, 1, dc, cnt);
      checks++;
      if (hold_viol != 0) begin errors++; $display("FAIL stall_hold got %0d changes want 0", hold_viol); end
      checks++;
      if (obs_x.size() != exp_x.size() || cnt != 6) begin
         errors++; $display("FAIL stall_npix got %0d cnt=%0d want 6", obs_x.size(), cnt);
      end else
         for (int i = 0; i < exp_x.size(); i++) begin
            checks++;
            if (obs_x[i] !== exp_x[i] || obs_y[i] !== exp_y[i] || obs_last[i] !== exp_last[i]) begin
               errors++;
               $display("FAIL stall_pix%0d got %h/%h want %h/%h", i, obs_x[i], obs_y[i], exp_x[i], exp_y[i]);
            end
         end
   endtask

   task automatic test_empty();
      int dc, cnt;
      scan_box(16'h0140, 16'h00C0, 16'h0040, 16'h0080, 0, dc, cnt);
      checks++;
      if (obs_x.size() != 0 || dc != 1 || cnt != 0) begin
         errors++; $display("FAIL empty got npix=%0d cyc=%0d cnt=%0d want 0/1/0", obs_x.size(), dc, cnt);
      end
   endtask

   task automatic test_single();
      int dc, cnt;
      scan_box(16'h01FF, 16'h01C0, 16'h01C5, 16'h01FF, 0, dc, cnt);
      checks++;
      if (obs_x.size() != 1 || dc != 2 || cnt != 1) begin
         errors++; $display("FAIL single_cnt got npix=%0d cyc=%0d cnt=%0d want 1/2/1", obs_x.size(), dc, cnt);
      end else begin
         checks++;
         if (obs_x[0] !== 16'h01E0 || obs_y[0] !== 16'h01E0 || obs_last[0] !== 1'b1) begin
            errors++; $display("FAIL single_pix got %h/%h/%b want 01e0/01e0/1", obs_x[0], obs_y[0], obs_last[0]);
         end
      end
   endtask

   task automatic test_clip();
      int dc, cnt;
      build_exp(16'(318 * 64), 16'(400 * 64), 16'h0000, 16'h0000);
      scan_box(16'(318 * 64), 16'(400 * 64), 16'h0000, 16'h0000, 0, dc, cnt);
      checks++;
      if (obs_x.size() != exp_x.size() || cnt != exp_x.size()) begin
         errors++; $display("FAIL clip_npix got %0d cnt=%0d want %0d", obs_x.size(), cnt, exp_x.size());
      end else
         for (int i = 0; i < exp_x.size(); i++) begin
            checks++;
            if (obs_x[i] !== exp_x[i] || obs_last[i] !== exp_last[i]) begin
               errors++; $display("FAIL clip_pix%0d got %h/%b want %h/%b", i, obs_x[i], obs_last[i], exp_x[i], exp_last[i]);
            end
         end
`ifdef BBOX_SCANNER_CLIP_EN
      scan_box(16'(330 * 64), 16'(400 * 64), 16'h0000, 16'h0000, 0, dc, cnt);
      checks++;
      if (obs_x.size() != 0 || dc != 1 || cnt != 0) begin
         errors++; $display("FAIL clip_empty got npix=%0d cyc=%0d cnt=%0d want 0/1/0", obs_x.size(), dc, cnt);
      end
`endif
   endtask

   task automatic test_random();
      int dc, cnt, x0, x1, y0, y1;
      logic [15:0] bx0, bx1, by0, by1;
      for (int t = 0; t < 40; t++) begin
         x0 = $urandom_range(0, 330); x1 = x0 + $urandom_range(0, 7) - 1;
         y0 = $urandom_range(0, 245); y1 = y0 + $urandom_range(0, 6) - 1;
         if (x1 < 0) x1 = 0;
         if (y1 < 0) y1 = 0;
         bx0 = 16'(x0 * 64 + $urandom_range(0, 63)); bx1 = 16'(x1 * 64 + $urandom_range(0, 63));
         by0 = 16'(y0 * 64 + $urandom_range(0, 63)); by1 = 16'(y1 * 64 + $urandom_range(0, 63));
         build_exp(bx0, bx1, by0, by1);
         scan_box(bx0, bx1, by0, by1, t % 3 == 0 ? 0 : 2, dc, cnt);
         checks++;
         if (obs_x.size() != exp_x.size() || cnt != exp_x.size() || dc < 1 || hold_viol != 0) begin
            errors++;
            $display("FAIL rand%0d_count got npix=%0d cnt=%0d cyc=%0d hold=%0d want %0d", t, obs_x.size(), cnt,
                     dc, hold_viol, exp_x.size());
         end else
            for (int i = 0; i < exp_x.size(); i++) begin
               checks++;
               if (obs_x[i] !== exp_x[i] || obs_y[i] !== exp_y[i] || obs_last[i] !== exp_last[i]) begin
                  errors++;
                  $display("FAIL rand%0d_pix%0d got %h/%h/%b want %h/%h/%b", t, i, obs_x[i], obs_y[i], obs_last[i],
                           exp_x[i], exp_y[i], exp_last[i]);
                  break;
               end
            end
         if (t % 3 == 0 && dc >= 1) begin
            checks++;
            if (dc != exp_x.size() + 1) begin
               errors++; $display("FAIL rand%0d_lat got %0d want %0d", t, dc, exp_x.size() + 1);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int n = 0, ndone = 0, dc, cnt, w = 0;
      while (bb.bbox_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
      bb.xmin = 16'(10 * 64); bb.xmax = 16'(13 * 64); bb.ymin = 16'(20 * 64); bb.ymax = 16'(23 * 64);
      bb.bbox_valid = 1'b1; pix.pix_ready = 1'b1;
      @(negedge clk);
      bb.bbox_valid = 1'b0;
      repeat (3) begin
         if (pix.pix_valid === 1'b1) n++;
         @(negedge clk);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (n != 3 || pix.pix_valid !== 1'b0 || pix.px !== 16'h0 || pix.py !== 16'h0 || pix.pix_last !== 1'b0 ||
          done !== 1'b0 || bb.bbox_ready !== 1'b0 || pix_count !== '0) begin
         errors++;
         $display("FAIL rstmid_async got n=%0d v=%b px=%h py=%h d=%b rdy=%b cnt=%0d want 3 then zeros", n,
                  pix.pix_valid, pix.px, pix.py, done, bb.bbox_ready, pix_count);
      end
      @(negedge clk);
      rst = 1'b0;
      pix.pix_ready = 1'b0;
      repeat (6) begin
         if (done === 1'b1 || pix.pix_valid === 1'b1) ndone++;
         @(negedge clk);
      end
      checks++;
      if (ndone != 0) begin errors++; $display("FAIL rstmid_nodone got %0d active cycles want 0", ndone); end
      build_exp(16'(2 * 64), 16'(4 * 64), 16'(5 * 64), 16'(6 * 64));
      scan_box(16'(2 * 64), 16'(4 * 64), 16'(5 * 64), 16'(6 * 64), 0, dc, cnt);
      checks++;
      if (obs_x.size() != exp_x.size() || cnt != exp_x.size() || dc != exp_x.size() + 1) begin
         errors++; $display("FAIL rstmid_next got npix=%0d cnt=%0d cyc=%0d want %0d", obs_x.size(), cnt, dc, exp_x.size());
      end else
         for (int i = 0; i < exp_x.size(); i++) begin
            checks++;
            if (obs_x[i] !== exp_x[i] || obs_y[i] !== exp_y[i] || obs_last[i] !== exp_last[i]) begin
               errors++; $display("FAIL rstmid_pix%0d got %h/%h want %h/%h", i, obs_x[i], obs_y[i], exp_x[i], exp_y[i]);
            end
         end
   endtask

   initial begin
      bb.xmin = '0; bb.xmax = '0; bb.ymin = '0; bb.ymax = '0;
      bb.bbox_valid = 1'b0; pix.pix_ready = 1'b0;
      test_reset();
      test_basic();
      test_stall();
      test_empty();
      test_single();
      test_clip();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
